// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared register-file widths and control constants
package regfile_wb_arbiter_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b1;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// rtl/regfile_wb_arbiter_wb_queue.sv - ALU result circular queue with per-entry valid bits, kill and busy match
module regfile_wb_arbiter_wb_queue
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [ADDR_W-1:0] i_kill_addr,
  input  logic [ADDR_W-1:0] i_match_addr1,
  input  logic [ADDR_W-1:0] i_match_addr2,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_head_valid,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_match1,
  output logic              o_match2
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  assign o_full       = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_head_valid = r_valid[r_rd_ptr];
  assign o_head_addr  = r_addr[r_rd_ptr];
  assign o_head_data  = r_data[r_rd_ptr];

  // Pointers, occupancy and valid bits; a popped slot is cleared so stale entries never match.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && (r_addr[i] == i_kill_addr)) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        // A same-edge load to the same register is younger, so the new entry is born dead.
        r_valid[r_wr_ptr] <= !(i_kill_en && (i_push_addr == i_kill_addr));
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
    end
  end

  // Entry payload storage; needs no reset because the valid bits gate every use.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Address match of live entries against the two decode read ports.
  always_comb begin
    o_match1 = 1'b0;
    o_match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == i_match_addr1)) o_match1 = 1'b1;
      if (r_valid[i] && (r_addr[i] == i_match_addr2)) o_match2 = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter merging loads and queued ALU results (option: REGWB_PERF_EN)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W      = RegBus,
  parameter int ADDR_W      = RegAddrBus,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [ADDR_W-1:0] i_alu_waddr,
  input  logic [DATA_W-1:0] i_alu_wdata,
  input  logic              i_mem_valid,
  input  logic [ADDR_W-1:0] i_mem_waddr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
`ifdef REGWB_PERF_EN
  output logic [31:0]       o_perf_stall_cnt,
  output logic [31:0]       o_perf_conflict_cnt,
`endif
  output logic              o_busy1,
  output logic              o_busy2
);

  logic              w_full;
  logic              w_empty;
  logic              w_head_valid;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_qmatch1;
  logic              w_qmatch2;
  logic              w_alu_ready;
  logic              w_alu_acc;
  logic              w_push;
  logic              w_load_wr;
  logic              w_pop;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  // Loads own the port whenever they target a real register; the queue only drains otherwise.
  assign w_alu_ready = !w_full;
  assign w_alu_acc   = i_alu_valid && w_alu_ready;
  assign w_push      = w_alu_acc && (i_alu_waddr != '0);
  assign w_load_wr   = i_mem_valid && (i_mem_waddr != '0);
  assign w_pop       = !w_load_wr && !w_empty;

  regfile_wb_arbiter_wb_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (w_push),
    .i_push_addr   (i_alu_waddr),
    .i_push_data   (i_alu_wdata),
    .i_pop         (w_pop),
    .i_kill_en     (w_load_wr),
    .i_kill_addr   (i_mem_waddr),
    .i_match_addr1 (i_raddr1),
    .i_match_addr2 (i_raddr2),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_head_valid  (w_head_valid),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_match1      (w_qmatch1),
    .o_match2      (w_qmatch2)
  );

  // Registered write port: load first, then a live queue head; address/data hold when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst == RstEnable) begin
      r_we    <= WriteDisable;
      r_waddr <= '0;
      r_wdata <= ZeroWord;
    end else if (w_load_wr) begin
      r_we    <= WriteEnable;
      r_waddr <= i_mem_waddr;
      r_wdata <= i_mem_wdata;
    end else if (w_pop && w_head_valid) begin
      r_we    <= WriteEnable;
      r_waddr <= w_head_addr;
      r_wdata <= w_head_data;
    end else begin
      r_we    <= WriteDisable;
    end
  end

  assign o_alu_ready = w_alu_ready;
  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;

  // A register is busy while any write to it is queued or arriving this cycle.
  assign o_busy1 = (i_raddr1 != '0) &&
                   (w_qmatch1 || (i_mem_valid && (i_mem_waddr == i_raddr1)) ||
                    (w_alu_acc && (i_alu_waddr == i_raddr1)));
  assign o_busy2 = (i_raddr2 != '0) &&
                   (w_qmatch2 || (i_mem_valid && (i_mem_waddr == i_raddr2)) ||
                    (w_alu_acc && (i_alu_waddr == i_raddr2)));

`ifdef REGWB_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_conflict_cnt;

  // Free-running event counters for ALU backpressure and load-vs-head conflicts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst == RstEnable) begin
      r_stall_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (i_alu_valid && !w_alu_ready) r_stall_cnt    <= r_stall_cnt + 32'd1;
      if (w_load_wr && w_head_valid)   r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt    = r_stall_cnt;
  assign o_perf_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter (REGWB_PERF_EN optional)
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_waddr = '0;
  logic [31:0] alu_wdata = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        alu_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy1;
  logic        busy2;
`ifdef REGWB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_waddr (alu_waddr),
    .i_alu_wdata (alu_wdata),
    .i_mem_valid (mem_valid),
    .i_mem_waddr (mem_waddr),
    .i_mem_wdata (mem_wdata),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata),
    .i_raddr1    (raddr1),
    .i_raddr2    (raddr2),
`ifdef REGWB_PERF_EN
    .o_perf_stall_cnt    (perf_stall_cnt),
    .o_perf_conflict_cnt (perf_conflict_cnt),
`endif
    .o_busy1     (busy1),
    .o_busy2     (busy2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain list of pending ALU writes plus the expected write-port state.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_head;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_rdy;
  bit          m_ld;
  int unsigned m_stall;
  int unsigned m_conf;

  function automatic bit exp_busy(input logic [4:0] r);
    bit b;
    b = 1'b0;
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].v && mq[i].a == r) b = 1'b1;
    if (mem_valid && mem_waddr == r) b = 1'b1;
    if (alu_valid && (mq.size() < DEPTH) && alu_waddr == r) b = 1'b1;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_stall = 0; m_conf = 0;
    end else begin
      m_rdy = (mq.size() < DEPTH);
      m_ld  = mem_valid && (mem_waddr != 5'd0);
      if (alu_valid && !m_rdy) m_stall++;
      if (m_ld && mq.size() > 0 && mq[0].v) m_conf++;
      if (m_ld) begin
        foreach (mq[i]) if (mq[i].a == mem_waddr) mq[i].v = 1'b0;
        m_we = 1'b1; m_waddr = mem_waddr; m_wdata = mem_wdata;
      end else if (mq.size() > 0) begin
        m_head = mq.pop_front();
        m_we = m_head.v;
        if (m_head.v) begin
          m_waddr = m_head.a; m_wdata = m_head.d;
        end
      end else begin
        m_we = 1'b0;
      end
      if (alu_valid && m_rdy && alu_waddr != 5'd0)
        mq.push_back('{a: alu_waddr, d: alu_wdata, v: !(m_ld && alu_waddr == mem_waddr)});
    end
  end

  // Every cycle, mid-period: DUT outputs against the model.
  always @(negedge clk) begin
    chk("m_alu_ready", alu_ready, mq.size() < DEPTH);
    chk("m_busy1", busy1, exp_busy(raddr1));
    chk("m_busy2", busy2, exp_busy(raddr2));
    chk("m_we", we, m_we);
    chk("m_waddr", waddr, m_waddr);
    chk("m_wdata", wdata, m_wdata);
`ifdef REGWB_PERF_EN
    chk("m_perf_stall", perf_stall_cnt, m_stall);
    chk("m_perf_conflict", perf_conflict_cnt, m_conf);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
  endtask

  initial begin
    raddr2 = 5'd9;
    #2;
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_ready", alu_ready, 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: single ALU write r3=0x11, visible two cycles later
    raddr1 = 5'd3;
    drive(1, 5'd3, 32'h11, 0, 0, 0);
    #1 chk("t1_busy_c0", busy1, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("t1_busy_c1", busy1, 1'b1);
    chk("t1_we_c1", we, 1'b0);
    tick();
    chk("t1_we_c2", we, 1'b1);
    chk("t1_waddr_c2", waddr, 5'd3);
    chk("t1_wdata_c2", wdata, 32'h11);
    chk("t1_busy_c2", busy1, 1'b0);

    // 2: ALU r1..r4 (then r5 refused) against a continuous load to r9
    raddr1 = 5'd4;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1, 5'(k + 1), 32'hA0 + k, 1, 5'd9, 32'h90 + k);
      else       drive(1, 5'd5, 32'hA5, 1, 5'd9, 32'h90 + k);
      #1 chk("t2_ready", alu_ready, (k < 4) ? 1'b1 : 1'b0);
      tick();
      chk("t2_load_we", we, 1'b1);
      chk("t2_load_waddr", waddr, 5'd9);
      chk("t2_load_wdata", wdata, 32'h90 + k);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t2_drain_we", we, 1'b1);
      chk("t2_drain_waddr", waddr, 5'(j + 1));
      chk("t2_drain_wdata", wdata, 32'hA0 + j);
    end

    // 3: queued r5=0xAA superseded by load r5=0xBB
    raddr1 = 5'd5;
    drive(1, 5'd5, 32'hAA, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 5'd5, 32'hBB);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("t3_we", we, 1'b1);
    chk("t3_wdata", wdata, 32'hBB);
    chk("t3_busy_killed", busy1, 1'b0);
    tick();
    chk("t3_killed_we", we, 1'b0);
    chk("t3_hold_waddr", waddr, 5'd5);
    chk("t3_hold_wdata", wdata, 32'hBB);

    // 4: writes to r0 vanish
    raddr1 = 5'd0;
    drive(1, 5'd0, 32'hFF, 1, 5'd0, 32'h1);
    #1 chk("t4_busy_r0", busy1, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_we_c1", we, 1'b0);
    tick();
    chk("t4_we_c2", we, 1'b0);

    // 5: reset with three queued entries
    raddr1 = 5'd6;
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(6 + k), 32'h60 + k, 1, 5'd10, 32'h100 + k);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("t5_busy_pre", busy1, 1'b1);
    chk("t5_we_pre", we, 1'b1);
    rst = 1'b1;
    #1 chk("t5_we_rst", we, 1'b0);
    chk("t5_ready_rst", alu_ready, 1'b1);
    chk("t5_busy_rst", busy1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t5_we_after", we, 1'b0);
    end

`ifdef REGWB_PERF_EN
    // 6: nine blocked cycles -> four accepts then five stalls; head valid for eight of them
    for (int k = 0; k < 9; k++) begin
      drive(1, (k < 4) ? 5'(k + 1) : 5'd5, 32'hC0 + k, 1, 5'd9, 32'h70 + k);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_stall_cnt", perf_stall_cnt, 32'd5);
    chk("t6_conflict_cnt", perf_conflict_cnt, 32'd8);
    for (int j = 0; j < 5; j++) tick();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
